// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling, optional even-parity check (UART_RX_PARITY_EN).
// Frames are LSB-first; dout and the error flags update only on rx_done_tick.
module uart_rx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_tick,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err,
  output logic       parity_err
);

  // Tick counter widens only when the stop period exceeds 16 ticks.
  localparam int unsigned SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int unsigned NW = 3;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state, state_n;
  logic [SW-1:0] s, s_n;
  logic [NW-1:0] n, n_n;
  logic [7:0]    b, b_n;
  logic [7:0]    b_align;
  logic [7:0]    dout_n;
  logic          done_n;
  logic          ferr_n;
  logic          rx_q1, rx_s;

  // Two-flop synchronizer, reset to the idle-high line level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_s  <= rx_q1;
    end
  end

  // Data bits enter at the MSB, so a short frame sits in the top DBIT bits.
  assign b_align = b >> (8 - DBIT);

`ifdef UART_RX_PARITY_EN
  logic pend, pend_n;
  logic perr_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      pend       <= pend_n;
      parity_err <= perr_n;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_n;
      s            <= s_n;
      n            <= n_n;
      b            <= b_n;
      dout         <= dout_n;
      rx_done_tick <= done_n;
      frame_err    <= ferr_n;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    b_n     = b;
    dout_n  = dout;
    done_n  = 1'b0;
    ferr_n  = frame_err;
`ifdef UART_RX_PARITY_EN
    pend_n  = pend;
    perr_n  = parity_err;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == SW'(7)) begin
            if (!rx_s) begin
              state_n = DATA;
              s_n     = '0;
              n_n     = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_n = s + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == SW'(15)) begin
            s_n = '0;
            b_n = {rx_s, b[7:1]};
            if (n == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end else begin
              n_n = n + NW'(1);
            end
          end else begin
            s_n = s + SW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s == SW'(15)) begin
            s_n     = '0;
            pend_n  = rx_s ^ (^b_align);
            state_n = STOP;
          end else begin
            s_n = s + SW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s == SW'(SB_TICK - 1)) begin
            state_n = IDLE;
            s_n     = '0;
            done_n  = 1'b1;
            dout_n  = b_align;
            ferr_n  = ~rx_s;
`ifdef UART_RX_PARITY_EN
            perr_n  = pend;
`endif
          end else begin
            s_n = s + SW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level model with an expected-frame queue
// and a per-cycle compare of the pulse, the received byte and the held flags.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       s_tick;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
  logic       parity_err;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_tick       (s_tick),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   tick_per = 1;
  int   tick_cnt = 0;
  exp_t expq[$];
  exp_t pulses[$];
  exp_t last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Baud-enable generator: one pulse every tick_per clocks.
  initial begin
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_cnt++;
      if (tick_cnt >= tick_per) begin
        tick_cnt = 0;
        s_tick   = 1'b1;
      end else begin
        s_tick = 1'b0;
      end
    end
  end

  // Every cycle: a pulse must match the oldest expected frame, otherwise outputs hold.
  always @(negedge clk) begin
    exp_t e;
    if (rx_done_tick === 1'b1) begin
      pulses.push_back({dout, frame_err, parity_err});
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got pulse with dout %0h, required no pulse", dout);
      end else begin
        e = expq.pop_front();
        check("dout", 32'(dout), 32'(e.d));
        check("frame_err", 32'(frame_err), 32'(e.fe));
        check("parity_err", 32'(parity_err), 32'(e.pe));
        last = e;
      end
    end else begin
      check("hold_dout", 32'(dout), 32'(last.d));
      check("hold_frame_err", 32'(frame_err), 32'(last.fe));
      check("hold_parity_err", 32'(parity_err), 32'(last.pe));
    end
  end

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (s_tick) k++;
    end
    #1;
  endtask

  task automatic send_bit(input logic v, input int n);
    rx = v;
    wait_ticks(n);
  endtask

  // Drive one frame; rst_bit >= 0 pulses reset in the middle of that data bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok,
                            input int rst_bit);
    exp_t e;
    logic pe_exp;
    send_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      if (i == rst_bit) begin
        rx = d[i];
        wait_ticks(8);
        reset_n = 1'b0;
        expq.delete();
        last = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_ticks(8);
      end else begin
        send_bit(d[i], 16);
      end
    end
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ ~par_ok, 16);
    pe_exp = ~par_ok;
`else
    pe_exp = 1'b0 & par_ok;
`endif
    if (rst_bit < 0) begin
      e.d  = d;
      e.fe = ~stop;
      e.pe = pe_exp;
      expq.push_back(e);
    end
    send_bit(stop, 16);
    rx = 1'b1;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (expq.size() != 0 && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, 32'(expq.size()), 32'd0);
    expq.delete();
  endtask

  initial begin
    int         n0;
    logic [7:0] d;
    logic       ok;
    int         gap;

    reset_n = 1'b0;
    rx      = 1'b1;
    last    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_done", 32'(rx_done_tick), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    check("reset_parity_err", 32'(parity_err), 32'h0);
    reset_n = 1'b1;
    wait_ticks(5);

    tick_per = 1;
    send_frame(8'h55, 1'b1, 1'b1, -1);
    drain("drain_55");
    check("lit_55_dout", 32'(dout), 32'h55);
    check("lit_55_fe", 32'(frame_err), 32'h0);

    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(40);
    check("glitch_dout", 32'(dout), 32'h55);
    check("glitch_pulses", 32'(pulses.size()), 32'd1);

    send_frame(8'hA3, 1'b0, 1'b1, -1);
    wait_ticks(32);
    drain("drain_a3");
    check("lit_a3_dout", 32'(dout), 32'hA3);
    check("lit_a3_fe", 32'(frame_err), 32'h1);
    send_frame(8'h00, 1'b1, 1'b1, -1);
    drain("drain_00");
    check("lit_00_dout", 32'(dout), 32'h00);
    check("lit_00_fe", 32'(frame_err), 32'h0);

    send_frame(8'hFF, 1'b1, 1'b1, 4);
    wait_ticks(16);
    check("reset_frame_pulses", 32'(pulses.size()), 32'd3);
    check("reset_frame_dout", 32'(dout), 32'h00);
    send_frame(8'h3C, 1'b1, 1'b1, -1);
    drain("drain_3c");
    check("lit_3c_dout", 32'(dout), 32'h3C);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, -1);
    drain("drain_par_bad");
    check("lit_par_bad", 32'(parity_err), 32'h1);
    send_frame(8'h07, 1'b1, 1'b1, -1);
    drain("drain_par_ok");
    check("lit_par_ok", 32'(parity_err), 32'h0);
`endif

    tick_per = 4;
    n0 = pulses.size();
    send_frame(8'h12, 1'b1, 1'b1, -1);
    send_frame(8'h34, 1'b1, 1'b1, -1);
    drain("drain_b2b");
    check("b2b_pulses", 32'(pulses.size() - n0), 32'd2);
    if (pulses.size() >= n0 + 2) begin
      check("b2b_first", 32'(pulses[n0].d), 32'h12);
      check("b2b_second", 32'(pulses[n0+1].d), 32'h34);
    end

    repeat (40) begin
      tick_per = $urandom_range(1, 4);
      d        = 8'($urandom);
      ok       = ($urandom_range(0, 3) != 0);
      send_frame(d, 1'b1, ok, -1);
      gap = $urandom_range(0, 12);
      if (gap > 0) send_bit(1'b1, gap);
      drain("drain_rand");
    end

    wait_ticks(40);
    check("final_queue", 32'(expq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
